sequential_divider: RTL and testbench
=====================================

Name: sequential_divider

Overview:
Iterative restoring divider for the MIPS datapath, implementing DIV/DIVU. It is the subtract-and-shift counterpart to the datapath adder.
- Accepts operands with a start pulse and produces quotient (LO) and remainder (HI) after a fixed number of cycles.
- Uses a busy/done handshake so the control unit can stall until the result is ready.

Parameters:
NBits, 32, operand and result width.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_Start  input  1  request; sampled only in IDLE
in_Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with in_Start
in_Dividend  input  NBits  dividend (rs); sampled with in_Start
in_Divisor  input  NBits  divisor (rt); sampled with in_Start
out_Busy  output  1  high while an operation is in progress
out_Done  output  1  single-cycle pulse when results update
out_Quotient  output  NBits  quotient, destined for LO
out_Remainder  output  NBits  remainder, destined for HI
out_DivByZero  output  1  last completed operation had divisor 0

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- On reset assertion, at any time including mid-operation:
  - state goes to IDLE; the operation is aborted with no done pulse.
  - all outputs reset to 0.
- States:
  - IDLE, RUN, FIX.
  - out_Busy = 1 in RUN and FIX; 0 in IDLE.
- IDLE:
  - When in_Start = 1 at edge k: latch in_Signed; latch the operand magnitudes (the absolute value of each operand when signed, the raw value when unsigned); latch the quotient and remainder sign flags.
  - Clear the partial remainder and load the iteration counter with NBits.
  - Divisor = 0 → go to FIX and set the zero flag. Otherwise → go to RUN.
- RUN, one bit per cycle, MSB first:
  - Shift the partial remainder left, bringing in the next dividend bit.
  - Trial-subtract the divisor magnitude using an NBits+1-bit subtract.
  - If the result is non-negative, keep it and shift a 1 into the quotient; else restore and shift a 0.
  - Decrement the counter. The counter reaching 0 moves the state to FIX.
- FIX, one cycle, then back to IDLE. At the FIX→IDLE edge:
  - Register out_Quotient, out_Remainder and out_DivByZero.
  - Set out_Done = 1 for exactly one cycle.
- Latency:
  - Normal operation: out_Done rises at edge k+NBits+1 (33 cycles at NBits = 32).
  - Divide-by-zero: out_Done rises at edge k+1.
- Sign rules (signed mode only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes are computed on NBits+1 bits, so the most negative value converts correctly.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0. No flag is raised.
- Divide by zero, either mode: quotient = all ones, remainder = in_Dividend unchanged, out_DivByZero = 1.
- Holding and handshake:
  - Outputs hold their values between completions.
  - in_Start while out_Busy = 1 is ignored; there is no queuing.
  - in_Start may be asserted in the same cycle out_Done is high. That request is accepted, since the state is IDLE.
- Operands may change after the accepting edge without affecting the result.

Optional Feature:
DIVIDER_EARLY_EXIT_EN
- Defined: in IDLE, if divisor ≠ 0 and |dividend| < |divisor| (both unsigned magnitudes), the block skips RUN and goes directly to FIX. Result: quotient 0, remainder = in_Dividend, out_Done at edge k+1.
- Undefined: every nonzero-divisor operation takes the full NBits+1 cycles.
- Results are identical in both builds; only latency differs.

Test Plan:
- Unsigned 100 / 7 → Q = 14, R = 2, DivByZero = 0; out_Done exactly one cycle at edge k+33; out_Busy high for 33 cycles.
- Signed 0xFFFFFFF9 (−7) / 2 → Q = 0xFFFFFFFD, R = 0xFFFFFFFF. Signed 7 / 0xFFFFFFFE (−2) → Q = 0xFFFFFFFD, R = 1.
- Signed 0x80000000 / 0xFFFFFFFF → Q = 0x80000000, R = 0. The same operands unsigned → Q = 0, R = 0x80000000.
- 5 / 0, either mode → Q = 0xFFFFFFFF, R = 5, DivByZero = 1, out_Done at edge k+1. A following 9 / 3 clears DivByZero and gives Q = 3, R = 0.
- Start 1000 / 10, pulse in_Start again at cycle 5 with 8 / 2 → the second request is ignored; result Q = 100, R = 0.
- Start 1000 / 10, assert reset at cycle 12 → outputs 0, out_Busy = 0, no out_Done. After release, 6 / 4 → Q = 1, R = 2.
- With DIVIDER_EARLY_EXIT_EN: 3 / 10 → Q = 0, R = 3, done at edge k+1. Without it: same result, done at k+33.

Source files
------------

// File: rtl/sequential_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider
//
// Iterative restoring divider for the MIPS datapath (DIV / DIVU). Produces
// one quotient bit per clock, MSB first. The quotient goes to LO and the
// remainder goes to HI. A busy/done handshake lets the control unit stall
// until the result is ready.
//
// Handshake: a request is taken on a rising edge where in_Start = 1 and
// the block is idle (out_Busy = 0). Operands are captured on that edge.
// out_Done pulses for one cycle when the result outputs update. A request
// made while busy is dropped.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset; aborts any operation
//   in_Start       request, sampled only when idle
//   in_Signed      1 = DIV (two's complement), 0 = DIVU
//   in_Dividend    dividend (rs)
//   in_Divisor     divisor (rt)
//   out_Busy       high while an operation is in progress (RUN or FIX)
//   out_Done       one-cycle pulse when the result outputs update
//   out_Quotient   quotient (LO)
//   out_Remainder  remainder (HI)
//   out_DivByZero  last completed operation had a zero divisor
//
// Optional build macro DIVIDER_EARLY_EXIT_EN:
//   When |dividend| < |divisor| and the divisor is nonzero, the iterations
//   are skipped and the result is ready one cycle after the start edge.
//   Results are the same in both builds; only the latency differs.
// ---------------------------------------------------------------------------
module sequential_divider #(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Start,
    input  logic             in_Signed,
    input  logic [NBits-1:0] in_Dividend,
    input  logic [NBits-1:0] in_Divisor,
    output logic             out_Busy,
    output logic             out_Done,
    output logic [NBits-1:0] out_Quotient,
    output logic [NBits-1:0] out_Remainder,
    output logic             out_DivByZero
);

    localparam int CW = $clog2(NBits + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Working registers. dvd_q holds the dividend magnitude. As the dividend
    // bits shift out at the top, quotient bits shift in at the bottom, so at
    // the end of RUN dvd_q holds the quotient magnitude.
    logic [NBits-1:0] dvd_q, dvd_d;
    logic [NBits-1:0] dvs_q, dvs_d;
    logic [NBits-1:0] prem_q, prem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    // bypass_q: the result comes from the raw dividend in dvd_q, not from
    // the iterations (zero divisor, or early exit).
    logic             bypass_q, bypass_d;
    logic             zero_q, zero_d;

    // Result registers
    logic [NBits-1:0] quot_q, quot_d;
    logic [NBits-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    // Operand magnitudes. The negation is done on NBits+1 bits so that the
    // most negative value gives its true magnitude (for example 2^31).
    logic             dvd_is_neg, dvs_is_neg;
    logic [NBits-1:0] mag_dvd, mag_dvs;

    always_comb begin
        dvd_is_neg = in_Signed & in_Dividend[NBits-1];
        dvs_is_neg = in_Signed & in_Divisor[NBits-1];
        mag_dvd    = dvd_is_neg ? NBits'(~{1'b1, in_Dividend} + 1'b1) : in_Dividend;
        mag_dvs    = dvs_is_neg ? NBits'(~{1'b1, in_Divisor} + 1'b1) : in_Divisor;
    end

    // Trial subtraction on NBits+1 bits. The partial remainder is always
    // below the divisor, so the shifted value minus the divisor fits in
    // NBits+1 bits. Its top bit is therefore a true sign bit.
    logic [NBits:0] trial;

    always_comb begin
        trial = {prem_q, dvd_q[NBits-1]} - {1'b0, dvs_q};
    end

    // Sign fix-up of the magnitudes computed in RUN
    logic [NBits-1:0] quot_fix, rem_fix;

    always_comb begin
        quot_fix = q_neg_q ? (~dvd_q + 1'b1)  : dvd_q;
        rem_fix  = r_neg_q ? (~prem_q + 1'b1) : prem_q;
    end

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        prem_d   = prem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        bypass_d = bypass_q;
        zero_d   = zero_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_Start) begin
                    dvd_d    = mag_dvd;
                    dvs_d    = mag_dvs;
                    prem_d   = '0;
                    cnt_d    = CW'(NBits);
                    q_neg_d  = dvd_is_neg ^ dvs_is_neg;
                    r_neg_d  = dvd_is_neg;
                    bypass_d = 1'b0;
                    zero_d   = 1'b0;
                    if (in_Divisor == '0) begin
                        // The raw dividend is kept because it becomes the remainder.
                        dvd_d    = in_Dividend;
                        bypass_d = 1'b1;
                        zero_d   = 1'b1;
                        state_d  = FIX;
`ifdef DIVIDER_EARLY_EXIT_EN
                    end else if (mag_dvd < mag_dvs) begin
                        dvd_d    = in_Dividend;
                        bypass_d = 1'b1;
                        state_d  = FIX;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (trial[NBits]) begin
                    // Negative: restore (keep the shifted remainder), quotient bit 0
                    prem_d = {prem_q[NBits-2:0], dvd_q[NBits-1]};
                    dvd_d  = {dvd_q[NBits-2:0], 1'b0};
                end else begin
                    prem_d = trial[NBits-1:0];
                    dvd_d  = {dvd_q[NBits-2:0], 1'b1};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (bypass_q) begin
                    quot_d = zero_q ? '1 : '0;
                    rem_d  = dvd_q;
                end else begin
                    quot_d = quot_fix;
                    rem_d  = rem_fix;
                end
                dbz_d   = zero_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            prem_q   <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            bypass_q <= 1'b0;
            zero_q   <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            prem_q   <= prem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            bypass_q <= bypass_d;
            zero_q   <= zero_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign out_Busy      = (state_q != IDLE);
    assign out_Done      = done_q;
    assign out_Quotient  = quot_q;
    assign out_Remainder = rem_q;
    assign out_DivByZero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// ---------------------------------------------------------------------------
// tb_sequential_divider
//
// Directed vectors with hand-computed results. The driver pushes each
// expected result and its expected completion edge into exp_q. A monitor
// pops an entry on every out_Done pulse and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_sequential_divider;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_Start;
    logic         in_Signed;
    logic [W-1:0] in_Dividend;
    logic [W-1:0] in_Divisor;
    logic         out_Busy;
    logic         out_Done;
    logic [W-1:0] out_Quotient;
    logic [W-1:0] out_Remainder;
    logic         out_DivByZero;

    sequential_divider #(.NBits(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_Start      (in_Start),
        .in_Signed     (in_Signed),
        .in_Dividend   (in_Dividend),
        .in_Divisor    (in_Divisor),
        .out_Busy      (out_Busy),
        .out_Done      (out_Done),
        .out_Quotient  (out_Quotient),
        .out_Remainder (out_Remainder),
        .out_DivByZero (out_DivByZero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;  // number of rising edges seen
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic [31:0]  cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
        return (s && v[W-1]) ? (~v + 1'b1) : v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!reset && out_Done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", out_Quotient, e.q);
                chk("remainder", out_Remainder, e.r);
                chk("div_by_zero", {31'd0, out_DivByZero}, {31'd0, e.z});
                chk("done_edge", cyc, e.cyc);
            end
        end
        if (!reset && prev_done) chk("done_width", {31'd0, out_Done}, 32'd0);
        prev_done <= out_Done && !reset;
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; the request is taken on the next rising edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez);
        exp_t e;
        int   lat;
        lat = (b == '0) ? 1 : 33;
`ifdef DIVIDER_EARLY_EXIT_EN
        if (b != '0 && mag(a, s) < mag(b, s)) lat = 1;
`endif
        in_Start    = 1'b1;
        in_Signed   = s;
        in_Dividend = a;
        in_Divisor  = b;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.z   = ez;
            e.cyc = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        // Operands changing after the start edge must not disturb the result.
        in_Start    = 1'b0;
        in_Signed   = $urandom_range(0, 1);
        in_Dividend = $urandom;
        in_Divisor  = $urandom;
    endtask

    // Returns on the falling edge where out_Done is high.
    task automatic wait_done();
        int n;
        n = 0;
        while (!out_Done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_Done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        vecs[0]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[3]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[4]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
        vecs[5]  = '{1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0};
        vecs[6]  = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
        vecs[7]  = '{1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[11] = '{1'b1, 32'h80000000, 32'd0,        32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[12] = '{1'b1, 32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        int busy_cnt;
        reset       = 1'b1;
        in_Start    = 1'b0;
        in_Signed   = 1'b0;
        in_Dividend = '0;
        in_Divisor  = '0;
        #1;
        chk("reset_quotient", out_Quotient, 32'd0);
        chk("reset_remainder", out_Remainder, 32'd0);
        chk("reset_flags", {29'd0, out_Busy, out_Done, out_DivByZero}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned 100 / 7, with the busy window measured.
        issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 100 && !out_Done; i++) begin
            if (out_Busy) busy_cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", busy_cnt, 32'd33);
        chk("busy_low_at_done", {31'd0, out_Busy}, 32'd0);

        // Table, each request issued in the cycle where the previous done is high.
        for (int i = 0; i < NV; i++) begin
            wait_done();
            issue(vecs[i].s, vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].r, vecs[i].z);
        end
        wait_done();
        @(negedge clk);

        // A second start while busy is dropped.
        issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        in_Start    = 1'b1;
        in_Signed   = 1'b0;
        in_Dividend = 32'd8;
        in_Divisor  = 32'd2;
        @(negedge clk);
        in_Start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // Reset in the middle of an operation: no done, outputs cleared.
        issue(1'b0, 32'd1000, 32'd10, 1'b0, '0, '0, 1'b0);
        repeat (11) @(negedge clk);
        chk("busy_before_abort", {31'd0, out_Busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_quotient", out_Quotient, 32'd0);
        chk("abort_remainder", out_Remainder, 32'd0);
        chk("abort_flags", {29'd0, out_Busy, out_Done, out_DivByZero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", {31'd0, out_Busy, out_Done}, 32'd0);

        issue(1'b0, 32'd6, 32'd4, 1'b1, 32'd1, 32'd2, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
